// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared definitions for the TDC measurement sequencer:
//                sequencer state encoding and hamming-weight width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  // Hamming weight of an N-tap line ranges 0..N, so it needs clog2(N)+1 bits.
  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Sequencer state encoding (kept as plain constants for legacy tools).
  typedef logic [2:0] tdc_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LAUNCH  = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_SAMPLE  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_stat_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_stat_acc
//  Description : Burst statistics for TDC hamming weights: running sum,
//                minimum, maximum and a sticky out-of-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_stat_acc
  import tdc_pkg::*;
#(
  parameter int N    = 64,
  parameter int HW_W = hw_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            acc_i,
  input  logic [HW_W-1:0] hw_i,
  output logic [HW_W+7:0] sum_o,
  output logic [HW_W-1:0] min_o,
  output logic [HW_W-1:0] max_o,
  output logic            err_o
);

  logic [HW_W+7:0] sum_q, sum_d;
  logic [HW_W-1:0] min_q, min_d;
  logic [HW_W-1:0] max_q, max_d;
  logic            err_q, err_d;

  // Clear has priority; otherwise fold the current weight into the stats.
  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    err_d = err_q;
    if (clr_i) begin
      sum_d = '0;
      min_d = '1;
      max_d = '0;
      err_d = 1'b0;
    end else if (acc_i) begin
      sum_d = sum_q + {8'd0, hw_i};
      if (hw_i < min_q) min_d = hw_i;
      if (hw_i > max_q) max_d = hw_i;
      if (hw_i > HW_W'(N)) err_d = 1'b1;
    end
  end

  // Statistics registers; min idles at all-ones so the first sample wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      err_q <= err_d;
    end
  end

  assign sum_o = sum_q;
  assign min_o = min_q;
  assign max_o = max_q;
  assign err_o = err_q;

endmodule : tdc_stat_acc
`default_nettype wire

// File: rtl/tdc_meas_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_meas_seq
//  Description : Measurement-burst sequencer for a tapped-delay-line TDC.
//                Issues launch/capture strobes, waits for the synchronised
//                hamming weight to settle, and accumulates burst statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_meas_seq
  import tdc_pkg::*;
#(
  parameter  int N      = 64,
  parameter  int SETTLE = 2,
  localparam int HW_W   = hw_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      cfg_samples,
  input  logic [3:0]      cfg_cap_dly,
  input  logic            cfg_tog,
  input  logic [HW_W-1:0] hw_in,
  output logic            launch_o,
  output logic            capture_o,
  output logic            pg_tog_o,
  output logic            busy,
  output logic            done,
  output logic [HW_W+7:0] sum_o,
  output logic [HW_W-1:0] min_o,
  output logic [HW_W-1:0] max_o,
  output logic            err_o
);

  // Settle counter must hold SETTLE itself; +1 keeps it non-zero width.
  localparam int SET_W = $clog2(SETTLE + 1) + 1;

  tdc_state_t       state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;        // samples taken so far
  logic [8:0]       tgt_q, tgt_d;        // latched samples per burst (1..256)
  logic [3:0]       cap_dly_q, cap_dly_d;
  logic             tog_en_q, tog_en_d;
  logic [3:0]       dly_q, dly_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             pg_q, pg_d;

  logic             w_stat_clr;
  logic             w_stat_acc;

  // Next-state and datapath control; abort overrides everything when busy.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    cap_dly_d  = cap_dly_q;
    tog_en_d   = tog_en_q;
    dly_d      = dly_q;
    settle_d   = settle_q;
    pg_d       = pg_q;
    w_stat_clr = 1'b0;
    w_stat_acc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          tgt_d      = (cfg_samples == 8'd0) ? 9'd256 : {1'b0, cfg_samples};
          cap_dly_d  = cfg_cap_dly;
          tog_en_d   = cfg_tog;
          cnt_d      = '0;
          pg_d       = 1'b0;
          w_stat_clr = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (cap_dly_q != 4'd0) begin
          dly_d   = cap_dly_q;
          state_d = ST_DELAY;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DELAY: begin
        if (dly_q <= 4'd1) state_d = ST_CAPTURE;
        else               dly_d   = dly_q - 4'd1;
      end
      ST_CAPTURE: begin
        if (SETTLE > 0) begin
          settle_d = SET_W'(SETTLE);
          state_d  = ST_SETTLE;
        end else begin
          state_d  = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q <= SET_W'(1)) state_d  = ST_SAMPLE;
        else                       settle_d = settle_q - SET_W'(1);
      end
      ST_SAMPLE: begin
        w_stat_acc = 1'b1;
        cnt_d      = cnt_q + 9'd1;
        if (tog_en_q) pg_d = ~pg_q;
        if ((cnt_q + 9'd1) == tgt_q) state_d = ST_DONE;
        else                         state_d = ST_LAUNCH;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort drops the burst immediately; a sample in flight is not taken.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      w_stat_acc = 1'b0;
      cnt_d      = cnt_q;
      pg_d       = pg_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tgt_q     <= '0;
      cap_dly_q <= '0;
      tog_en_q  <= 1'b0;
      dly_q     <= '0;
      settle_q  <= '0;
      pg_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      cap_dly_q <= cap_dly_d;
      tog_en_q  <= tog_en_d;
      dly_q     <= dly_d;
      settle_q  <= settle_d;
      pg_q      <= pg_d;
    end
  end

  tdc_stat_acc #(
    .N    (N),
    .HW_W (HW_W)
  ) u_stat_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (w_stat_clr),
    .acc_i (w_stat_acc),
    .hw_i  (hw_in),
    .sum_o (sum_o),
    .min_o (min_o),
    .max_o (max_o),
    .err_o (err_o)
  );

  // Strobes and status decode straight from the state register.
  assign launch_o  = (state_q == ST_LAUNCH);
  assign capture_o = (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign pg_tog_o  = pg_q;

endmodule : tdc_meas_seq
`default_nettype wire

// File: tb/tb_tdc_meas_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_meas_seq
//  Description : Self-checking bench for tdc_meas_seq with a timing and
//                statistics reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_meas_seq;

  localparam int N      = 64;
  localparam int SETTLE = 2;
  localparam int HW_W   = $clog2(N) + 1;
  localparam int MINRST = (1 << HW_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [7:0]      cfg_samples = '0;
  logic [3:0]      cfg_cap_dly = '0;
  logic            cfg_tog = 1'b0;
  logic [HW_W-1:0] hw_in = '0;
  logic            launch_o, capture_o, pg_tog_o, busy, done, err_o;
  logic [HW_W+7:0] sum_o;
  logic [HW_W-1:0] min_o, max_o;

  int n_assert = 0;
  int n_fail   = 0;
  int hw_vals[256];
  int done_at;
  int sum_hold;

  always #5 clk = ~clk;

  tdc_meas_seq #(.N(N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_samples (cfg_samples),
    .cfg_cap_dly (cfg_cap_dly),
    .cfg_tog     (cfg_tog),
    .hw_in       (hw_in),
    .launch_o    (launch_o),
    .capture_o   (capture_o),
    .pg_tog_o    (pg_tog_o),
    .busy        (busy),
    .done        (done),
    .sum_o       (sum_o),
    .min_o       (min_o),
    .max_o       (max_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_launch"}, 32'(launch_o), 0);
    chk({tag, "_capture"}, 32'(capture_o), 0);
    chk({tag, "_pg"}, 32'(pg_tog_o), 0);
    chk({tag, "_sum"}, 32'(sum_o), 0);
    chk({tag, "_min"}, 32'(min_o), MINRST);
    chk({tag, "_max"}, 32'(max_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  // One burst: per-cycle strobe/status timing from the sample-period rule,
  // statistics from plain arithmetic over hw_vals. abort_cyc=0 means none.
  task automatic run_burst(input string tag, input int s_cfg, input int dly,
                           input bit tog, input int abort_cyc, output int done_seen);
    int s, p, done_cyc, last, k, r;
    int sum_m, min_m, max_m;
    bit err_m, pg_m, active, el, ec, ed, eb;
    s        = (s_cfg == 0) ? 256 : s_cfg;
    p        = 3 + dly + SETTLE;
    done_cyc = s * p + 1;
    last     = (abort_cyc > 0) ? abort_cyc + 1 : done_cyc;
    sum_m = 0; min_m = MINRST; max_m = 0; err_m = 0; pg_m = 0;
    done_seen = -1;
    @(negedge clk);
    cfg_samples = 8'(s_cfg);
    cfg_cap_dly = 4'(dly);
    cfg_tog     = tog;
    start       = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      k = (cyc - 1) / p;
      r = (cyc - 1) % p;
      active = (abort_cyc == 0) || (cyc <= abort_cyc);
      el = active && (r == 0) && (k < s);
      ec = active && (r == 1 + dly) && (k < s);
      ed = active && (cyc == done_cyc);
      eb = active && (cyc <= done_cyc);
      chk({tag, "_launch"}, 32'(launch_o), 32'(el));
      chk({tag, "_capture"}, 32'(capture_o), 32'(ec));
      chk({tag, "_done"}, 32'(done), 32'(ed));
      chk({tag, "_busy"}, 32'(busy), 32'(eb));
      if (launch_o && capture_o) chk({tag, "_strobe_overlap"}, 1, 0);
      if (done && done_seen < 0) done_seen = cyc;
      // Sample taken at the last cycle of each period unless aborted there.
      if ((r == p - 1) && (k < s) && ((abort_cyc == 0) || (cyc < abort_cyc))) begin
        sum_m += hw_vals[k];
        if (hw_vals[k] < min_m) min_m = hw_vals[k];
        if (hw_vals[k] > max_m) max_m = hw_vals[k];
        if (hw_vals[k] > N) err_m = 1;
        if (tog) pg_m = ~pg_m;
      end
      // Drive next inputs: junk start/cfg while busy, valid hw from capture on.
      start = (cyc == 2);
      abort = (cyc == abort_cyc);
      cfg_samples = 8'($urandom);
      cfg_cap_dly = 4'($urandom);
      cfg_tog     = 1'($urandom);
      if ((k < s) && (r >= 1 + dly)) hw_in = HW_W'(hw_vals[k]);
      else                           hw_in = HW_W'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    chk({tag, "_sum"}, 32'(sum_o), 32'(sum_m));
    chk({tag, "_min"}, 32'(min_o), 32'(min_m));
    chk({tag, "_max"}, 32'(max_o), 32'(max_m));
    chk({tag, "_err"}, 32'(err_o), 32'(err_m));
    chk({tag, "_pg"}, 32'(pg_tog_o), 32'(pg_m));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_hold_sum"}, 32'(sum_o), 32'(sum_m));
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);

    // Single sample, no capture delay.
    hw_vals[0] = 32;
    run_burst("single", 1, 0, 0, 0, done_at);
    chk("single_done_cycle", 32'(done_at), 6);
    chk("single_sum_const", 32'(sum_o), 32);

    // Four samples, capture delay 3.
    hw_vals[0] = 10; hw_vals[1] = 40; hw_vals[2] = 5; hw_vals[3] = 64;
    run_burst("four", 4, 3, 0, 0, done_at);
    chk("four_done_cycle", 32'(done_at), 33);
    chk("four_sum_const", 32'(sum_o), 119);
    chk("four_min_const", 32'(min_o), 5);
    chk("four_max_const", 32'(max_o), 64);

    // start together with abort in IDLE is ignored; results untouched.
    sum_hold = int'(sum_o);
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_launch", 32'(launch_o), 0);
    @(negedge clk);
    chk("start_abort_busy2", 32'(busy), 0);
    chk("start_abort_sum", 32'(sum_o), 32'(sum_hold));

    // One out-of-range weight sets the sticky error.
    for (int i = 0; i < 5; i++) hw_vals[i] = int'($urandom_range(0, N));
    hw_vals[$urandom_range(0, 3)] = N + 1;
    run_burst("err", 5, int'($urandom_range(0, 15)), 0, 0, done_at);
    chk("err_const", 32'(err_o), 1);

    // Random bursts, including capture-delay boundaries.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) hw_vals[i] = int'($urandom_range(0, N));
      run_burst("rand", int'($urandom_range(1, 8)),
                (b == 0) ? 15 : int'($urandom_range(0, 15)), 0, 0, done_at);
    end

    // 256-sample burst at full-scale weight.
    for (int i = 0; i < 256; i++) hw_vals[i] = N;
    run_burst("full", 0, 0, 0, 0, done_at);
    chk("full_sum_const", 32'(sum_o), 16384);
    chk("full_done_cycle", 32'(done_at), 256 * 5 + 1);

    // Abort during the delay of the second sample keeps partial results.
    for (int i = 0; i < 4; i++) hw_vals[i] = int'($urandom_range(0, N));
    run_burst("abort", 4, 3, 0, 11, done_at);
    chk("abort_no_done", 32'(done_at), 32'(-1));
    chk("abort_partial_sum", 32'(sum_o), 32'(hw_vals[0]));

    // Reset asserted mid-burst: immediate return to reset values.
    @(negedge clk);
    cfg_samples = 8'd4; cfg_cap_dly = 4'd3; cfg_tog = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_after_busy", 32'(busy), 0);
      chk("rst_mid_after_done", 32'(done), 0);
    end

    // Pulse-generator toggle: off, then on for three samples.
    for (int i = 0; i < 3; i++) hw_vals[i] = int'($urandom_range(0, N));
    run_burst("tog_off", 3, int'($urandom_range(0, 15)), 0, 0, done_at);
    chk("tog_off_const", 32'(pg_tog_o), 0);
    run_burst("tog_on", 3, int'($urandom_range(0, 15)), 1, 0, done_at);
    chk("tog_on_const", 32'(pg_tog_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_tdc_meas_seq
`default_nettype wire

// File: doc/tdc_meas_seq.md
TDC_MEAS_SEQ -- requirements
Module: tdc_meas_seq

Interface
REQ-001 Parameter N, default 64: number of delay-line taps in the TDC being sequenced.
REQ-002 Parameter SETTLE, default 2: cycles to wait after capture before sampling hw (covers N_SYNC plus the popcount).
REQ-003 Localparam HW_W = $clog2(N)+1: hamming-weight width (7 for N=64).
REQ-004 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a measurement burst; sampled only in IDLE.
REQ-007 abort  in  1  terminate the burst and return to IDLE without done.
REQ-008 cfg_samples  in  8  samples per burst; 0 means 256.
REQ-009 cfg_cap_dly  in  4  clk cycles between launch and capture strobes.
REQ-010 cfg_tog  in  1  when 1, invert pg_tog_o after every sample.
REQ-011 hw_in  in  HW_W  hamming weight returned by the TDC.
REQ-012 launch_o  out  1  one-cycle launch strobe to the TDC.
REQ-013 capture_o  out  1  one-cycle capture strobe to the TDC.
REQ-014 pg_tog_o  out  1  pulse-generator toggle level.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a burst completes.
REQ-017 sum_o  out  HW_W+8  accumulated hw over the burst.
REQ-018 min_o / max_o  out  HW_W each  extremes of hw over the burst.
REQ-019 err_o  out  1  sticky flag: some sample had hw_in > N.

Function
REQ-020 The FSM SHALL have the states IDLE, LAUNCH, DELAY, CAPTURE, SETTLE, SAMPLE and DONE.
REQ-021 In IDLE, start=1 SHALL latch cfg_*, clear sum_o=0, min_o=all-ones, max_o=0, err_o=0 and the sample counter, and go to LAUNCH.
REQ-022 LAUNCH SHALL last 1 cycle with launch_o=1, then go to DELAY if the latched cap_dly>0, else straight to CAPTURE.
REQ-023 DELAY SHALL last exactly cap_dly cycles.
REQ-024 CAPTURE SHALL last 1 cycle with capture_o=1.
REQ-025 SETTLE SHALL last SETTLE cycles.
REQ-026 SAMPLE SHALL last 1 cycle and perform all of the following on hw_in:
- sum_o += hw_in;
- min_o / max_o update;
- err_o |= (hw_in > N);
- when the latched cfg_tog=1, toggle pg_tog_o.
REQ-027 After SAMPLE, the FSM SHALL go to DONE if the samples taken equal the latched count, else to LAUNCH.
REQ-028 One sample period SHALL be 3 + cap_dly + SETTLE cycles.
REQ-029 DONE SHALL last 1 cycle with done=1, then go to IDLE; results SHALL hold until the next accepted start.
REQ-030 sum_o SHALL be wide enough never to overflow: 256 × N ≤ 2^(HW_W+8)-1.
REQ-031 A start asserted while busy=1 SHALL be ignored.
REQ-032 A start and abort asserted together in IDLE SHALL be ignored (abort wins).
REQ-033 abort in any busy state SHALL go to IDLE on the next edge with strobes low, done not asserted, and the partial results kept.
REQ-034 launch_o and capture_o SHALL never be high in the same cycle.
REQ-035 cfg_* changes SHALL have no effect while busy.

Reset
REQ-036 While rst_n=0, the FSM SHALL be forced to IDLE with all outputs 0 except min_o = all-ones, asynchronously.
REQ-037 Reset asserted mid-burst SHALL abandon the burst with no done pulse.
REQ-038 Reset release SHALL take effect synchronously on the next clk edge.

Structure
REQ-039 The state enum and the HW_W computation SHALL live in the shared package tdc_pkg.
REQ-040 The stats datapath (sum/min/max/err) SHALL be the sub-module tdc_stat_acc, with clear and accumulate-enable inputs.
REQ-041 The block SHALL contain no combinational path from hw_in to any output.

Verification
REQ-042 cfg_samples=1, cap_dly=0, SETTLE=2, hw_in=32 -> launch at cycle 1, capture at cycle 2, done at cycle 6; sum=32, min=max=32.
REQ-043 cfg_samples=4, cap_dly=3, hw_in sequence 10, 40, 5, 64 -> sum=119, min=5, max=64, err=0; done 4×8+1 cycles after start.
REQ-044 cfg_samples=0, hw_in=64 constant -> 256 launch pulses, sum=16384, no overflow.
REQ-045 hw_in=65 on one sample -> err_o=1 and it stays set to done; start pulsed while busy -> no restart.
REQ-046 abort raised in DELAY of sample 2, then rst_n pulsed low mid-burst -> busy falls next edge, no done pulse, outputs at reset values.
REQ-047 cfg_tog=1, cfg_samples=3 -> pg_tog_o toggles 3 times, ending at 1; with cfg_tog=0 it stays at 0.
